// File: rtl/j2_io_responder.sv
// IO-space responder for the j2 core: LED register, tick counter, transmit FIFO
// toward the host, and a one-entry receive mailbox from the host.
module j2_io_responder #(
  parameter int WIDTH    = 16,
  parameter int TX_DEPTH = 4
) (
  input  logic             clock,
  input  logic             active_low_reset,
  input  logic             io_write_enable,
  input  logic [15:0]      memory_address,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] io_data_in,
  output logic [WIDTH-1:0] leds,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_strobe,
  output logic             rx_ready
);

  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = $clog2(TX_DEPTH + 1);

  localparam logic [15:0] A_LEDS   = 16'h0000;
  localparam logic [15:0] A_TXDATA = 16'h0001;
  localparam logic [15:0] A_STATUS = 16'h0002;
  localparam logic [15:0] A_RXDATA = 16'h0003;
  localparam logic [15:0] A_TICKS  = 16'h0004;

  logic [WIDTH-1:0] leds_q, ticks_q, ticks_d;
  logic [7:0]       fifo_q [TX_DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;

  logic wr_leds, wr_tx, wr_status, wr_rx, wr_ticks;
  logic tx_full, tx_empty, pop, push_ok, push_drop;

  assign wr_leds   = io_write_enable && (memory_address == A_LEDS);
  assign wr_tx     = io_write_enable && (memory_address == A_TXDATA);
  assign wr_status = io_write_enable && (memory_address == A_STATUS);
  assign wr_rx     = io_write_enable && (memory_address == A_RXDATA);
  assign wr_ticks  = io_write_enable && (memory_address == A_TICKS);

  assign tx_full   = (cnt_q == CW'(TX_DEPTH));
  assign tx_empty  = (cnt_q == '0);
  assign pop       = !tx_empty && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign push_ok   = wr_tx && (!tx_full || pop);
  assign push_drop = wr_tx && !push_ok;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Overflow set takes priority over a software clear.
  always_comb begin
    ovf_d = ovf_q;
    if (push_drop)                   ovf_d = 1'b1;
    else if (wr_status && data_out[3]) ovf_d = 1'b0;
  end

  assign ticks_d = wr_ticks ? data_out : ticks_q + WIDTH'(1);

  always_ff @(posedge clock or negedge active_low_reset) begin
    if (!active_low_reset) begin
      leds_q     <= '0;
      ticks_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (wr_leds) leds_q <= data_out;
      ticks_q <= ticks_d;
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop)     rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      // A strobe coinciding with the core's ack refills the mailbox at once.
      if (rx_strobe && (!rx_valid_q || wr_rx)) begin
        rx_byte_q  <= rx_data;
        rx_valid_q <= 1'b1;
      end else if (wr_rx) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_q[wr_q] <= data_out[7:0];
  end

  assign leds     = leds_q;
  assign tx_data  = fifo_q[rd_q];
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_valid_q;

  always_comb begin
    io_data_in = '0;
    case (memory_address)
      A_LEDS:   io_data_in = leds_q;
      A_STATUS: io_data_in = {(WIDTH-4)'(cnt_q), ovf_q, rx_valid_q, tx_empty, tx_full};
      A_RXDATA: io_data_in = WIDTH'(rx_byte_q);
      A_TICKS:  io_data_in = ticks_q;
      default:  io_data_in = '0;
    endcase
  end

endmodule

// File: tb/tb_j2_io_responder.sv
// Directed bench for j2_io_responder: register map, FIFO, mailbox, ticks, async reset.
module tb_j2_io_responder;

  logic        clock = 1'b0;
  logic        active_low_reset;
  logic        io_write_enable;
  logic [15:0] memory_address;
  logic [15:0] data_out;
  logic [15:0] io_data_in;
  logic [15:0] leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic        rx_ready;

  int asserts  = 0;
  int failures = 0;

  j2_io_responder #(.WIDTH(16), .TX_DEPTH(4)) dut (
    .clock(clock), .active_low_reset(active_low_reset),
    .io_write_enable(io_write_enable), .memory_address(memory_address),
    .data_out(data_out), .io_data_in(io_data_in), .leds(leds),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .rx_ready(rx_ready)
  );

  always #5 clock = ~clock;

  // One-cycle IO write, launched and retired on falling edges.
  task automatic io_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    io_write_enable = 1'b1; memory_address = a; data_out = d;
    @(negedge clock);
    io_write_enable = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    memory_address = a;
    #1;
  endtask

  task automatic test_reset();
    active_low_reset = 1'b0; io_write_enable = 1'b0; memory_address = '0;
    data_out = '0; tx_ready = 1'b0; rx_data = '0; rx_strobe = 1'b0;
    #2;
    rd(16'h0002);
    asserts++; if (io_data_in !== 16'h0002) begin failures++; $display("FAIL reset_status got %h exp 0002", io_data_in); end
    asserts++; if (leds !== 16'h0000) begin failures++; $display("FAIL reset_leds got %h exp 0000", leds); end
    asserts++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL reset_hs got tv=%b rr=%b exp 0 1", tx_valid, rx_ready); end
    @(negedge clock);
    active_low_reset = 1'b1;
  endtask

  task automatic test_ticks();
    logic [15:0] t0, t1;
    @(negedge clock);
    rd(16'h0004); t0 = io_data_in;
    @(negedge clock);
    rd(16'h0004); t1 = io_data_in;
    asserts++; if (t1 !== t0 + 16'd1) begin failures++; $display("FAIL ticks_inc got %h exp %h", t1, t0 + 16'd1); end
    io_wr(16'h0004, 16'hFFFF);
    rd(16'h0004);
    asserts++; if (io_data_in !== 16'hFFFF) begin failures++; $display("FAIL ticks_load got %h exp FFFF", io_data_in); end
    @(negedge clock);
    rd(16'h0004);
    asserts++; if (io_data_in !== 16'h0000) begin failures++; $display("FAIL ticks_wrap got %h exp 0000", io_data_in); end
  endtask

  task automatic test_leds();
    io_wr(16'h0000, 16'hA5C3);
    #1;
    asserts++; if (leds !== 16'hA5C3) begin failures++; $display("FAIL leds_out got %h exp A5C3", leds); end
    rd(16'h0000);
    asserts++; if (io_data_in !== 16'hA5C3) begin failures++; $display("FAIL leds_read got %h exp A5C3", io_data_in); end
    rd(16'h0007);
    asserts++; if (io_data_in !== 16'h0000) begin failures++; $display("FAIL unmapped_read got %h exp 0000", io_data_in); end
    io_wr(16'h0007, 16'h1234);
    rd(16'h0000);
    asserts++; if (io_data_in !== 16'hA5C3 || leds !== 16'hA5C3) begin failures++; $display("FAIL unmapped_write got %h exp A5C3", io_data_in); end
    rd(16'h0002);
    asserts++; if (io_data_in !== 16'h0002) begin failures++; $display("FAIL unmapped_write_status got %h exp 0002", io_data_in); end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    tx_ready = 1'b0;
    io_wr(16'h0001, 16'h0011);
    io_wr(16'h0001, 16'h0022);
    io_wr(16'h0001, 16'h0033);
    io_wr(16'h0001, 16'h0044);
    io_wr(16'h0001, 16'h0055);
    rd(16'h0002);
    asserts++; if (io_data_in !== 16'h0049) begin failures++; $display("FAIL ovf_status got %h exp 0049", io_data_in); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      asserts++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin failures++; $display("FAIL drain_%0d got v=%b d=%h exp 1 %h", i, tx_valid, tx_data, exp[i]); end
      @(negedge clock);
    end
    #1;
    asserts++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
    rd(16'h0002);
    asserts++; if (io_data_in !== 16'h000A) begin failures++; $display("FAIL ovf_sticky got %h exp 000A", io_data_in); end
    io_wr(16'h0002, 16'h0008);
    rd(16'h0002);
    asserts++; if (io_data_in !== 16'h0002) begin failures++; $display("FAIL ovf_clear got %h exp 0002", io_data_in); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    exp = '{8'hBB, 8'hCC, 8'hDD, 8'h66};
    tx_ready = 1'b0;
    io_wr(16'h0001, 16'h00AA);
    io_wr(16'h0001, 16'h00BB);
    io_wr(16'h0001, 16'h00CC);
    io_wr(16'h0001, 16'h00DD);
    @(negedge clock);
    tx_ready = 1'b1; io_write_enable = 1'b1; memory_address = 16'h0001; data_out = 16'h0066;
    @(negedge clock);
    tx_ready = 1'b0; io_write_enable = 1'b0;
    rd(16'h0002);
    asserts++; if (io_data_in !== 16'h0041) begin failures++; $display("FAIL pushpop_status got %h exp 0041", io_data_in); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      asserts++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin failures++; $display("FAIL pushpop_%0d got v=%b d=%h exp 1 %h", i, tx_valid, tx_data, exp[i]); end
      @(negedge clock);
    end
    #1;
    asserts++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL pushpop_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    @(negedge clock);
    rx_strobe = 1'b1; rx_data = 8'h7E;
    @(negedge clock);
    rx_strobe = 1'b0;
    rd(16'h0003);
    asserts++; if (io_data_in !== 16'h007E || rx_ready !== 1'b0) begin failures++; $display("FAIL rx_latch got %h rr=%b exp 007E 0", io_data_in, rx_ready); end
    rd(16'h0002);
    asserts++; if (io_data_in !== 16'h0006) begin failures++; $display("FAIL rx_status got %h exp 0006", io_data_in); end
    rx_strobe = 1'b1; rx_data = 8'h01;
    @(negedge clock);
    rx_strobe = 1'b0;
    rd(16'h0003);
    asserts++; if (io_data_in !== 16'h007E) begin failures++; $display("FAIL rx_ignore got %h exp 007E", io_data_in); end
    io_write_enable = 1'b1; data_out = 16'h0000; rx_strobe = 1'b1; rx_data = 8'h02;
    @(negedge clock);
    io_write_enable = 1'b0; rx_strobe = 1'b0;
    #1;
    asserts++; if (io_data_in !== 16'h0002 || rx_ready !== 1'b0) begin failures++; $display("FAIL rx_ack_refill got %h rr=%b exp 0002 0", io_data_in, rx_ready); end
    io_wr(16'h0003, 16'h0000);
    #1;
    asserts++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rx_ack got %b exp 1", rx_ready); end
  endtask

  task automatic test_async_reset();
    tx_ready = 1'b0;
    io_wr(16'h0001, 16'h0031);
    io_wr(16'h0001, 16'h0032);
    io_wr(16'h0001, 16'h0033);
    io_wr(16'h0000, 16'h5A5A);
    rx_strobe = 1'b1; rx_data = 8'h99;
    @(negedge clock);
    rx_strobe = 1'b0;
    rd(16'h0002);
    asserts++; if (io_data_in !== 16'h0034) begin failures++; $display("FAIL prereset_status got %h exp 0034", io_data_in); end
    @(posedge clock);
    #1;
    active_low_reset = 1'b0;
    #1;
    asserts++; if (io_data_in !== 16'h0002) begin failures++; $display("FAIL arst_status got %h exp 0002", io_data_in); end
    asserts++; if (leds !== 16'h0000 || tx_valid !== 1'b0 || rx_ready !== 1'b1) begin failures++; $display("FAIL arst_outputs got leds=%h tv=%b rr=%b exp 0000 0 1", leds, tx_valid, rx_ready); end
    rd(16'h0004);
    asserts++; if (io_data_in !== 16'h0000) begin failures++; $display("FAIL arst_ticks got %h exp 0000", io_data_in); end
    rd(16'h0003);
    asserts++; if (io_data_in !== 16'h0000) begin failures++; $display("FAIL arst_rxdata got %h exp 0000", io_data_in); end
    @(negedge clock);
    active_low_reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ticks();
    test_leds();
    test_fifo_overflow();
    test_back_to_back();
    test_rx();
    test_async_reset();
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/j2_io_responder.md
# j2_io_responder

IO-space responder on the far side of the j2 core's IO bus. It decodes the core's IO writes (`io_write_enable`, `memory_address`, `data_out`) and returns `io_data_in` for IO reads. It holds the peripheral state the firmware talks to:
- an LED/output register
- a free-running tick counter
- a transmit FIFO drained by a host-side ready/valid port
- a one-entry receive mailbox filled by a host-side strobe

## Interface
- `WIDTH`, 16, data word width; must match the core's `WIDTH`.
- `TX_DEPTH`, 4, transmit FIFO entries; power of two, 2..8.

- `clock` in 1: system clock, rising edge.
- `active_low_reset` in 1: asynchronous, active-low reset.
- `io_write_enable` in 1: core IO write strobe, one cycle per write.
- `memory_address` in 16: IO address. Decoded on all 16 bits.
- `data_out` in WIDTH: core write data.
- `io_data_in` out WIDTH: read data for `memory_address`.
- `leds` out WIDTH: LED register.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: host accepts the head byte.
- `rx_data` in 8: host byte.
- `rx_strobe` in 1: host byte present this cycle.
- `rx_ready` out 1: mailbox empty; equals `!rx_valid`.

## Operation
Address map. All reads are free of side effects. Unmapped addresses read 0 and ignore writes.
- **0x0000 LEDS**
  - Read: returns `leds`.
  - Write: loads `data_out`.
- **0x0001 TX_DATA**
  - Read: returns 0.
  - Write: pushes `data_out[7:0]`.
- **0x0002 STATUS**
  - Read: bit0 `tx_full`, bit1 `tx_empty`, bit2 `rx_valid`, bit3 `tx_overflow`, bits[WIDTH-1:4] `tx_count`, zero-extended.
  - Write: `data_out[3]`=1 clears `tx_overflow`; other bits are ignored.
- **0x0003 RX_DATA**
  - Read: returns the mailbox byte, zero-extended.
  - Write (any value): acknowledges, clearing `rx_valid`.
- **0x0004 TICKS**
  - Read: returns the counter.
  - Write: loads `data_out`.

TX FIFO (circular buffer, read/write pointers, count 0..TX_DEPTH):
- Pop occurs when `tx_valid && tx_ready` at the rising edge.
- Push is accepted when `count < TX_DEPTH`, or when a pop occurs in the same cycle.
  - Simultaneous push and pop: count is unchanged, head advances, byte stored.
- Push while full with no pop: the byte is dropped and `tx_overflow` is set (sticky).
  - If a STATUS clear and an overflowing push occur in the same cycle, set wins.
- Pointers wrap modulo TX_DEPTH.

RX mailbox:
- `rx_strobe` while `rx_valid`=0: the byte is latched and `rx_valid` is set.
- `rx_strobe` while `rx_valid`=1: the byte is ignored. The host must honour `rx_ready`.
- Core ack and `rx_strobe` in the same cycle: the new byte is latched and `rx_valid` stays 1.

Ticks:
- Increments by 1 every cycle and wraps from 2^WIDTH−1 to 0.
- A write to TICKS overrides that cycle's increment. The next cycle reads the written value, then counting resumes.

## Timing
- `io_data_in` is combinational from `memory_address` and registered state, valid in the same cycle. The core consumes it within its combinational ALU path.
- Writes take effect at the rising edge where `io_write_enable`=1. Effects are visible on reads and outputs from the next cycle.
- `tx_valid` and `tx_data` are driven from FIFO state. After a push into an empty FIFO, `tx_valid` rises one cycle later.
- After a pop, the next entry (or `tx_valid`=0) is presented the following cycle.
- `tx_data` is undefined when `tx_valid`=0; the bench must not check it.
- Reset (asynchronous, any time, including mid-transfer) immediately forces:
  - `leds`=0, ticks=0
  - FIFO empty: pointers 0, `tx_valid`=0
  - `tx_overflow`=0
  - `rx_valid`=0, `rx_ready`=1, mailbox byte=0
- `io_data_in` then reflects reset state (STATUS reads 0x0002).
- First tick increment occurs at the first rising edge after reset release.

## Test plan
- Reset release, read TICKS on two consecutive cycles → the values differ by 1. Write 0xFFFF to TICKS → next cycle reads 0xFFFF, the following cycle reads 0x0000.
- Write LEDS=0xA5C3 → `leds`=0xA5C3 next cycle. Read 0x0000 → 0xA5C3. Read 0x0007 → 0. Write 0x0007 → no state change.
- `tx_ready`=0, push 0x11, 0x22, 0x33, 0x44, 0x55 → STATUS reads 0x0049 (count 4, full, overflow). Then `tx_ready`=1 → bytes 0x11..0x44 emerge in order and the FIFO ends empty. Write STATUS 0x0008 → STATUS reads 0x0002.
- FIFO full with `tx_ready`=1 and a push of 0x66 in the same cycle → count stays 4, no overflow, 0x66 emerges last.
- Host `rx_strobe` 0x7E → `rx_ready`=0, RX_DATA reads 0x007E. Then host `rx_strobe` 0x01 → ignored. Core ack with a simultaneous strobe of 0x02 → RX_DATA reads 0x0002 and `rx_valid` stays 1.
- Assert reset with 3 bytes queued and `rx_valid`=1 → all outputs take their reset values immediately, before the next clock edge.
